// File: rtl/decoder_3to8_buf.sv
// Registered 3-to-8 one-hot decoder with valid/ready input and a 2-entry output FIFO.
// Optional even-parity checking on the input code is enabled by defining DEC_PARITY_EN.
module decoder_3to8_buf #(
    parameter int unsigned CNT_W          = 8,
    parameter bit          ACTIVE_LOW_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
`ifdef DEC_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:7]       out_onehot,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int unsigned DEPTH = 2;

    logic [0:7] mem [DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [0:7] dec_word;
    logic [0:7] head_word;
    logic       par_ok;
    logic       push_hs;
    logic       push;
    logic       pop;

    assign in_ready  = en && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push_hs   = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef DEC_PARITY_EN
    assign par_ok = ~(^{in_code, in_par});
`else
    assign par_ok = 1'b1;
`endif

    // A word with bad parity completes its handshake but is dropped.
    assign push = push_hs && par_ok;

    always_comb begin
        dec_word          = '0;
        dec_word[in_code] = 1'b1;
    end

    // Idle value is forced whenever the FIFO is empty so no stale word leaks out.
    assign head_word  = out_valid ? mem[rd_ptr] : '0;
    assign out_onehot = ACTIVE_LOW_OUT ? ~head_word : head_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            xfer_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef DEC_PARITY_EN
    // Sticky error flag; only flush or reset clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (flush) begin
            par_err <= 1'b0;
        end else if (push_hs && !par_ok) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_3to8_buf.sv
// Directed self-checking bench for decoder_3to8_buf (active-high and one-cold instances).
// Parity checks are compiled in when DEC_PARITY_EN is defined.
module tb_decoder_3to8_buf;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [2:0]       in_code;
    logic             out_ready;

    logic             in_ready,   in_ready_l;
    logic             out_valid,  out_valid_l;
    logic [0:7]       out_onehot, out_onehot_l;
    logic [1:0]       occ,        occ_l;
    logic [CNT_W-1:0] xfer_cnt,   xfer_cnt_l;

`ifdef DEC_PARITY_EN
    logic bad_par;
    logic in_par;
    logic par_err, par_err_l;
    assign in_par = (^in_code) ^ bad_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decoder_3to8_buf #(.CNT_W(CNT_W), .ACTIVE_LOW_OUT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef DEC_PARITY_EN
        .in_par(in_par), .par_err(par_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .occ(occ), .xfer_cnt(xfer_cnt)
    );

    decoder_3to8_buf #(.CNT_W(CNT_W), .ACTIVE_LOW_OUT(1'b1)) u_low (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_code(in_code),
`ifdef DEC_PARITY_EN
        .in_par(in_par), .par_err(par_err_l),
`endif
        .out_valid(out_valid_l), .out_ready(out_ready), .out_onehot(out_onehot_l),
        .occ(occ_l), .xfer_cnt(xfer_cnt_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    logic [0:7] exp_word;

    initial begin
        rst_n = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_code = 3'd0; out_ready = 1'b1;
`ifdef DEC_PARITY_EN
        bad_par = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #1;
        check("rst_occ",      32'(occ),          32'h0);
        check("rst_valid",    32'(out_valid),    32'h0);
        check("rst_onehot",   32'(out_onehot),   32'h00);
        check("rst_onehot_l", 32'(out_onehot_l), 32'hFF);
        check("rst_xfer",     32'(xfer_cnt),     32'h0);
        check("rst_in_ready", 32'(in_ready),     32'h1);
        #2 rst_n = 1'b1;
        step();

        // Streaming codes 0..7 with the consumer always ready.
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_code  = 3'(c);
            step();
            exp_word = 8'h80 >> c;
            check("stream_valid",  32'(out_valid),  32'h1);
            check("stream_onehot", 32'(out_onehot), 32'(exp_word));
            check("stream_occ",    32'(occ),        32'h1);
        end
        in_valid = 1'b0;
        step();
        check("stream_xfer",   32'(xfer_cnt),   32'd8);
        check("stream_empty",  32'(out_valid),  32'h0);
        check("stream_idle",   32'(out_onehot), 32'h00);

        // Back-pressure: fill with 3,5 and hold 6 until space frees up.
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd3; step();
        in_code = 3'd5; step();
        check("full_occ",   32'(occ),      32'd2);
        check("full_ready", 32'(in_ready), 32'h0);
        in_code = 3'd6; step();
        check("hold_occ",   32'(occ),        32'd2);
        check("hold_head",  32'(out_onehot), 32'h10);
        out_ready = 1'b1;
        step();
        check("drain1_head", 32'(out_onehot), 32'h04);
        check("drain1_occ",  32'(occ),        32'd1);
        step();
        check("drain2_head", 32'(out_onehot), 32'h02);
        check("drain2_occ",  32'(occ),        32'd1);
        in_valid = 1'b0;
        step();
        check("drain_xfer",  32'(xfer_cnt), 32'd11);
        check("drain_empty", 32'(occ),      32'd0);

        // Push and pop in the same cycle at occ=1.
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd1; step();
        check("pp_pre_head", 32'(out_onehot), 32'h40);
        out_ready = 1'b1; in_code = 3'd2; step();
        check("pp_occ",  32'(occ),        32'd1);
        check("pp_head", 32'(out_onehot), 32'h20);
        check("pp_xfer", 32'(xfer_cnt),   32'd12);

        // Flush while full discards the pending pop too.
        out_ready = 1'b0; in_code = 3'd7; step();
        check("pre_flush_occ", 32'(occ), 32'd2);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0;
        check("flush_occ",   32'(occ),        32'd0);
        check("flush_valid", 32'(out_valid),  32'h0);
        check("flush_idle",  32'(out_onehot), 32'h00);
        check("flush_xfer",  32'(xfer_cnt),   32'd12);

`ifdef DEC_PARITY_EN
        // Bad parity word is consumed but never delivered.
        out_ready = 1'b0;
        bad_par = 1'b1; in_valid = 1'b1; in_code = 3'd3; step();
        check("par_bad_occ", 32'(occ),     32'd0);
        check("par_err_set", 32'(par_err), 32'h1);
        bad_par = 1'b0; step();
        in_valid = 1'b0;
        check("par_good_word", 32'(out_onehot), 32'h10);
        check("par_err_stick", 32'(par_err),    32'h1);
        flush = 1'b1; step();
        flush = 1'b0;
        check("par_err_clr", 32'(par_err), 32'h0);
        out_ready = 1'b1;
`endif

        // Counter wrap: 256 pops from reset return xfer_cnt to zero.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i % 8);
            step();
        end
        check("wrap_255", 32'(xfer_cnt), 32'd255);
        in_valid = 1'b0;
        step();
        check("wrap_0", 32'(xfer_cnt), 32'd0);

        // Asynchronous reset while full clears outputs without waiting for an edge.
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd1; step();
        in_code = 3'd2; step();
        in_valid = 1'b0;
        check("prerst_occ", 32'(occ), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(out_valid),  32'h0);
        check("arst_onehot", 32'(out_onehot), 32'h00);
        check("arst_occ",    32'(occ),        32'd0);
        rst_n = 1'b1;
        step();

        // One-cold output and en deassertion while a word drains.
        check("low_idle", 32'(out_onehot_l), 32'hFF);
        in_valid = 1'b1; in_code = 3'd4; step();
        in_valid = 1'b0;
        check("low_code4",  32'(out_onehot_l), 32'hF7);
        check("high_code4", 32'(out_onehot),   32'h08);
        en = 1'b0;
        #1;
        check("en0_ready",   32'(in_ready),   32'h0);
        check("en0_ready_l", 32'(in_ready_l), 32'h0);
        in_valid = 1'b1; in_code = 3'd0; out_ready = 1'b1; step();
        in_valid = 1'b0;
        check("en0_drain_occ", 32'(occ),          32'd0);
        check("en0_drain_cnt", 32'(xfer_cnt),     32'd1);
        check("en0_low_idle",  32'(out_onehot_l), 32'hFF);
        step();
        check("en0_no_push", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
